sti_deserializer: RTL and testbench

Serial-to-parallel receiver for the STI serial link: the receive end of the stream the STI_DAC transmitter drives on `so_data`/`so_valid`. It samples one bit per clock while the serial valid is high and rebuilds the transmitted word using the same length, fill, bit-order and byte-select configuration the transmitter used. It recovers the 16-bit payload and flags framing and padding errors. It sits in loopback and self-check paths next to the STI transmitter.

---
 rtl/sti_deserializer.sv | 171 +++++++++++++++++
 tb/tb_sti_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sti_deserializer.sv
// STI serial-to-parallel receiver: rebuilds 8/16/24/32-bit frames from
// si_data/si_valid and extracts the 16-bit payload with error flags.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   si_data, si_valid   serial bit and its qualifier
//   rx_length           frame length (00=8, 01=16, 10=24, 11=32 bits)
//   rx_fill             24/32-bit: 1 = payload high, 0 = payload low
//   rx_msb              1 = MSB first, 0 = LSB first
//   rx_low              8-bit: 1 = byte to po_data[15:8], 0 = [7:0]
//   po_data, po_valid   recovered payload and its one-cycle strobe
//   po_len_err          frame ended early
//   po_pad_err          pad bits not all zero
//   word_cnt            frames completed since reset (wraps)
//   rx_busy             frame partially received
module sti_deserializer (
   input  logic        clk,
   input  logic        reset,
   input  logic        si_data,
   input  logic        si_valid,
   input  logic [1:0]  rx_length,
   input  logic        rx_fill,
   input  logic        rx_msb,
   input  logic        rx_low,
   output logic [15:0] po_data,
   output logic        po_valid,
   output logic        po_len_err,
   output logic        po_pad_err,
   output logic [7:0]  word_cnt,
   output logic        rx_busy
);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t      r_state;
   logic [5:0]  r_cnt;
   logic [31:0] r_word;
   logic [1:0]  r_len;
   logic        r_fill;
   logic        r_msb;
   logic        r_low;
   logic [15:0] r_data;
   logic        r_valid;
   logic        r_len_err;
   logic        r_pad_err;
   logic [7:0]  r_wcnt;

   logic [31:0] w_word;
   logic [5:0]  w_cnt_nxt;
   logic [5:0]  w_nbits;
   logic        w_done;
   logic [15:0] w_ext_data;
   logic        w_ext_pad;

   // MSB-first shifts toward the top; LSB-first writes bit k into W[k].
   always_comb begin
      w_word = r_word;
      if (r_msb)
         w_word = {r_word[30:0], si_data};
      else
         w_word = r_word | ({31'b0, si_data} << r_cnt[4:0]);
   end

   assign w_cnt_nxt = r_cnt + 6'd1;
   assign w_nbits   = {1'b0, r_len, 3'b000} + 6'd8;
   assign w_done    = (w_cnt_nxt == w_nbits);

   // Payload/pad extraction from the word including the bit being sampled.
   always_comb begin
      w_ext_data = 16'h0000;
      w_ext_pad  = 1'b0;
      case (r_len)
         2'd0: begin
            if (r_low)
               w_ext_data = {w_word[7:0], 8'h00};
            else
               w_ext_data = {8'h00, w_word[7:0]};
         end
         2'd1: w_ext_data = w_word[15:0];
         2'd2: begin
            if (r_fill) begin
               w_ext_data = w_word[23:8];
               w_ext_pad  = |w_word[7:0];
            end else begin
               w_ext_data = w_word[15:0];
               w_ext_pad  = |w_word[23:16];
            end
         end
         default: begin
            if (r_fill) begin
               w_ext_data = w_word[31:16];
               w_ext_pad  = |w_word[15:0];
            end else begin
               w_ext_data = w_word[15:0];
               w_ext_pad  = |w_word[31:16];
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 6'd0;
         r_word    <= 32'h0;
         r_len     <= 2'd0;
         r_fill    <= 1'b0;
         r_msb     <= 1'b0;
         r_low     <= 1'b0;
         r_data    <= 16'h0000;
         r_valid   <= 1'b0;
         r_len_err <= 1'b0;
         r_pad_err <= 1'b0;
         r_wcnt    <= 8'd0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (si_valid) begin
                  r_word  <= {31'b0, si_data};
                  r_len   <= rx_length;
                  r_fill  <= rx_fill;
                  r_msb   <= rx_msb;
                  r_low   <= rx_low;
                  r_cnt   <= 6'd1;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (si_valid) begin
                  r_word <= w_word;
                  r_cnt  <= w_cnt_nxt;
                  if (w_done) begin
                     r_state   <= S_IDLE;
                     r_cnt     <= 6'd0;
                     r_valid   <= 1'b1;
                     r_data    <= w_ext_data;
                     r_len_err <= 1'b0;
                     r_pad_err <= w_ext_pad;
                     r_wcnt    <= r_wcnt + 8'd1;
                  end
               end else begin
                  // valid dropped before the frame filled: short frame
                  r_state   <= S_IDLE;
                  r_cnt     <= 6'd0;
                  r_valid   <= 1'b1;
                  r_data    <= 16'h0000;
                  r_len_err <= 1'b1;
                  r_pad_err <= 1'b0;
                  r_wcnt    <= r_wcnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 6'd0;
            end
         endcase
      end
   end

   assign po_data    = r_data;
   assign po_valid   = r_valid;
   assign po_len_err = r_len_err;
   assign po_pad_err = r_pad_err;
   assign word_cnt   = r_wcnt;
   assign rx_busy    = (r_state == S_SHIFT);

endmodule

// File: tb/tb_sti_deserializer.sv
// Scoreboard bench for sti_deserializer: directed frames from the
// test plan followed by randomized frames, short frames and gaps.
module tb_sti_deserializer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        si_data = 1'b0;
   logic        si_valid = 1'b0;
   logic [1:0]  rx_length = 2'd0;
   logic        rx_fill = 1'b0;
   logic        rx_msb = 1'b0;
   logic        rx_low = 1'b0;
   logic [15:0] po_data;
   logic        po_valid;
   logic        po_len_err;
   logic        po_pad_err;
   logic [7:0]  word_cnt;
   logic        rx_busy;

   sti_deserializer dut (
      .clk        (clk),
      .reset      (reset),
      .si_data    (si_data),
      .si_valid   (si_valid),
      .rx_length  (rx_length),
      .rx_fill    (rx_fill),
      .rx_msb     (rx_msb),
      .rx_low     (rx_low),
      .po_data    (po_data),
      .po_valid   (po_valid),
      .po_len_err (po_len_err),
      .po_pad_err (po_pad_err),
      .word_cnt   (word_cnt),
      .rx_busy    (rx_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      logic        le;
      logic        pe;
      logic [7:0]  wc;
      int          c;
   } exp_t;

   exp_t       q[$];
   int         total = 0;
   int         bad = 0;
   logic [7:0] m_cnt = 8'd0;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, a, e);
      end
   endtask

   // Reference: frame word W of N bits -> payload/pad from length rules.
   task automatic push_full(input logic [1:0] len, input logic fill,
                            input logic low, input logic [31:0] w,
                            input int c);
      exp_t e;
      int n;
      int sh;
      logic [31:0] pad;
      n = 8 * (int'(len) + 1);
      pad = 32'h0;
      if (n == 8) begin
         e.d = low ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
      end else if (n == 16) begin
         e.d = w[15:0];
      end else begin
         sh = n - 16;
         if (fill) begin
            e.d = 16'((w >> sh) & 32'hFFFF);
            pad = w & ((32'd1 << sh) - 32'd1);
         end else begin
            e.d = w[15:0];
            pad = w >> 16;
         end
      end
      e.le = 1'b0;
      e.pe = (pad != 32'h0);
      m_cnt = m_cnt + 8'd1;
      e.wc = m_cnt;
      e.c = c;
      q.push_back(e);
   endtask

   task automatic push_short(input int c);
      exp_t e;
      e.d = 16'h0000;
      e.le = 1'b1;
      e.pe = 1'b0;
      m_cnt = m_cnt + 8'd1;
      e.wc = m_cnt;
      e.c = c;
      q.push_back(e);
   endtask

   // Sends nsend bits of an N-bit frame; config is scrambled after the
   // first bit since the receiver must use its latched copy.
   task automatic send(input logic [1:0] len, input logic fill,
                       input logic msb, input logic low,
                       input logic [31:0] w, input int nsend,
                       input int gap);
      int n;
      n = 8 * (int'(len) + 1);
      for (int i = 0; i < nsend; i++) begin
         @(negedge clk);
         if (i == 0) begin
            rx_length = len;
            rx_fill   = fill;
            rx_msb    = msb;
            rx_low    = low;
         end else begin
            rx_length = 2'($urandom);
            rx_fill   = 1'($urandom);
            rx_msb    = 1'($urandom);
            rx_low    = 1'($urandom);
         end
         si_valid = 1'b1;
         si_data  = msb ? w[n-1-i] : w[i];
         if (i == n - 1) push_full(len, fill, low, w, cyc + 1);
      end
      if (nsend < n) begin
         @(negedge clk);
         si_valid = 1'b0;
         si_data  = 1'($urandom);
         push_short(cyc + 1);
      end
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         si_valid  = 1'b0;
         si_data   = 1'($urandom);
         rx_length = 2'($urandom);
      end
   endtask

   // Monitor: pops one expectation per po_valid strobe.
   always @(posedge clk) begin
      exp_t e;
      #1;
      while (q.size() > 0 && q[0].c < cyc) begin
         e = q.pop_front();
         total++;
         bad++;
         $display("FAIL missed_valid: no po_valid at cycle %0d (now %0d)",
                  e.c, cyc);
      end
      if (po_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: po_valid=1 at cycle %0d, none expected",
                     cyc);
         end else begin
            e = q.pop_front();
            chk("valid_cycle", cyc, e.c);
            chk("po_data", {16'h0, po_data}, {16'h0, e.d});
            chk("po_len_err", {31'h0, po_len_err}, {31'h0, e.le});
            chk("po_pad_err", {31'h0, po_pad_err}, {31'h0, e.pe});
            chk("word_cnt", {24'h0, word_cnt}, {24'h0, e.wc});
            if (e.le) chk("busy_after_short", {31'h0, rx_busy}, 32'h0);
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, {16'h0, po_data}, 32'h0);
      chk({tag, "_valid"}, {31'h0, po_valid}, 32'h0);
      chk({tag, "_len_err"}, {31'h0, po_len_err}, 32'h0);
      chk({tag, "_pad_err"}, {31'h0, po_pad_err}, 32'h0);
      chk({tag, "_word_cnt"}, {24'h0, word_cnt}, 32'h0);
      chk({tag, "_busy"}, {31'h0, rx_busy}, 32'h0);
   endtask

   initial begin
      logic [1:0]  len;
      logic [31:0] w;
      logic        fill;
      int          n;
      int          sh;
      int          ns;

      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      reset = 1'b0;

      send(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000A53C, 16, 3);
      send(2'd0, 1'b0, 1'b0, 1'b1, 32'h0000008E, 8, 2);
      send(2'd0, 1'b0, 1'b0, 1'b0, 32'h0000008E, 8, 2);
      send(2'd2, 1'b1, 1'b1, 1'b0, 32'h00123400, 24, 2);
      send(2'd2, 1'b1, 1'b1, 1'b0, 32'h00123401, 24, 2);
      send(2'd3, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 32, 2);
      send(2'd3, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 20, 2);
      send(2'd0, 1'b0, 1'b1, 1'b0, 32'h0000005A, 8, 0);
      send(2'd0, 1'b0, 1'b1, 1'b0, 32'h000000C3, 8, 4);

      // reset in the middle of a 16-bit frame
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         rx_length = 2'd1;
         rx_msb    = 1'b1;
         si_valid  = 1'b1;
         si_data   = 1'($urandom);
      end
      @(negedge clk);
      chk("busy_mid_frame", {31'h0, rx_busy}, 32'h1);
      reset    = 1'b1;
      si_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_cnt = 8'd0;
      chk_zero("mid_reset");
      send(2'd1, 1'b0, 1'b1, 1'b0, 32'h0000FFFF, 16, 3);

      for (int k = 0; k < 250; k++) begin
         len  = 2'($urandom);
         fill = 1'($urandom);
         n    = 8 * (int'(len) + 1);
         w    = $urandom;
         if (n < 32) w = w & ((32'd1 << n) - 32'd1);
         if (n > 16 && $urandom_range(0, 1) == 0) begin
            sh = n - 16;
            if (fill) w = w & ~((32'd1 << sh) - 32'd1);
            else w = w & 32'hFFFF;
         end
         ns = ($urandom_range(0, 7) == 0) ? $urandom_range(1, n - 1) : n;
         send(len, fill, 1'($urandom), 1'($urandom), w, ns,
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3));
      end

      @(negedge clk);
      si_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("queue_empty", q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
